// File: rtl/imm_materializer_pkg.sv
// Shared constants for the constant materializer: MIPS opcodes, immediate-extender
// ops and the encoding form selected for a constant.
package imm_materializer_pkg;

    localparam int unsigned IEXT_OP_LEN = 2;

    localparam logic [IEXT_OP_LEN-1:0] IEXT_OP_ZERO_EXT   = 2'd0;
    localparam logic [IEXT_OP_LEN-1:0] IEXT_OP_SIGNED_EXT = 2'd1;
    localparam logic [IEXT_OP_LEN-1:0] IEXT_OP_SHIFTL16   = 2'd2;

    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_LUI   = 6'h0F;

    typedef enum logic [1:0] {
        FormOri,
        FormAddiu,
        FormLui,
        FormPair
    } form_e;

    function automatic logic [31:0] enc_itype(input logic [5:0] opc, input logic [4:0] rs,
                                              input logic [4:0] rt, input logic [15:0] imm);
        return {opc, rs, rt, imm};
    endfunction

endpackage

// File: rtl/imm_mat_classify.sv
// Picks the shortest instruction form for a 32-bit constant; first matching rule wins.
module imm_mat_classify
    import imm_materializer_pkg::*;
#(
    parameter bit ALLOW_SIGNED = 1'b1
) (
    input  logic [31:0] value,
    output logic [1:0]  form
);

    always_comb begin
        form = FormPair;
        if (value[31:16] == 16'h0000) begin
            form = FormOri;
        end else if (ALLOW_SIGNED && (&value[31:15])) begin
            form = FormAddiu;
        end else if (value[15:0] == 16'h0000) begin
            form = FormLui;
        end
    end

endmodule

// File: rtl/imm_materializer.sv
// Turns a 32-bit constant plus destination register into the shortest ORI/ADDIU/LUI
// sequence, one registered instruction beat at a time.
module imm_materializer
    import imm_materializer_pkg::*;
#(
    parameter bit ALLOW_SIGNED = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_value,
    input  logic [4:0]             in_rt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_instr,
    output logic [15:0]            out_imm,
    output logic [IEXT_OP_LEN-1:0] out_op,
    output logic                   out_last
);

    typedef enum logic [1:0] {
        StIdle,
        StOne,
        StFirst,
        StSecond
    } state_e;

    state_e      state_q;
    logic [15:0] lo_q;
    logic [4:0]  rt_q;

    logic [1:0]             form;
    logic [31:0]            first_instr;
    logic [IEXT_OP_LEN-1:0] first_op;
    logic                   first_last;
    state_e                 first_state;

    imm_mat_classify #(
        .ALLOW_SIGNED(ALLOW_SIGNED)
    ) u_classify (
        .value(in_value),
        .form (form)
    );

    assign in_ready = (state_q == StIdle);

    always_comb begin
        first_instr = enc_itype(OPC_LUI, 5'd0, in_rt, in_value[31:16]);
        first_op    = IEXT_OP_SHIFTL16;
        first_last  = 1'b0;
        first_state = StFirst;
        case (form)
            FormOri: begin
                first_instr = enc_itype(OPC_ORI, 5'd0, in_rt, in_value[15:0]);
                first_op    = IEXT_OP_ZERO_EXT;
                first_last  = 1'b1;
                first_state = StOne;
            end
            FormAddiu: begin
                first_instr = enc_itype(OPC_ADDIU, 5'd0, in_rt, in_value[15:0]);
                first_op    = IEXT_OP_SIGNED_EXT;
                first_last  = 1'b1;
                first_state = StOne;
            end
            FormLui: begin
                first_last  = 1'b1;
                first_state = StOne;
            end
            default: begin
                // Pair: LUI of the high half now, ORI of the latched low half next.
                first_last  = 1'b0;
                first_state = StFirst;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            lo_q      <= 16'h0000;
            rt_q      <= 5'd0;
            out_valid <= 1'b0;
            out_instr <= 32'h0000_0000;
            out_imm   <= 16'h0000;
            out_op    <= IEXT_OP_ZERO_EXT;
            out_last  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        lo_q      <= in_value[15:0];
                        rt_q      <= in_rt;
                        out_valid <= 1'b1;
                        out_instr <= first_instr;
                        out_imm   <= first_instr[15:0];
                        out_op    <= first_op;
                        out_last  <= first_last;
                        state_q   <= first_state;
                    end
                end
                StOne, StSecond: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StFirst: begin
                    if (out_ready) begin
                        out_instr <= enc_itype(OPC_ORI, rt_q, rt_q, lo_q);
                        out_imm   <= lo_q;
                        out_op    <= IEXT_OP_ZERO_EXT;
                        out_last  <= 1'b1;
                        state_q   <= StSecond;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/imm_materializer.md
Name: imm_materializer

Overview:
- Inverse of the immediate-extension path: accepts a 32-bit constant plus a destination register and emits the shortest MIPS instruction sequence that loads the constant into that register.
- Each emitted beat carries:
  - the full instruction word;
  - the 16-bit immediate field;
  - the IEXT op that the decode stage's immediate extender will apply.
- Sits in the boot/debug instruction-injection path, feeding the fetch-stage inject port. Lets test harnesses and the boot loader set registers without hand-assembling.

Parameters:
- ALLOW_SIGNED, 1, when 1 the ADDIU single-instruction form is allowed for negative values fitting 16-bit sign extension; when 0 those values use the two-beat form.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  constant request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high at a clk edge.
- in_value  in  32  constant to materialize.
- in_rt  in  5  destination register number.
- out_valid  out  1  instruction beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_instr  out  32  encoded instruction word.
- out_imm  out  16  immediate field, equal to out_instr[15:0].
- out_op  out  `IEXT_OP_LEN  extension op the decoder applies for this instruction.
- out_last  out  1  marks the final beat of the sequence.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; out_instr=0; out_imm=0; out_op=`IEXT_OP_ZERO_EXT; out_last=0.
- The output bus is registered. A beat becomes valid the cycle after acceptance.
- A beat is held stable while out_valid && !out_ready.
- in_ready=1 only in IDLE. No new request is taken while a sequence is pending.
- Encoding selection uses v=in_value, evaluated at acceptance, first match wins:
  1. v[31:16]==0 -> ORI rt,$0,v[15:0]; op ZERO_EXT; single beat.
  2. ALLOW_SIGNED && v[31:15] all ones -> ADDIU rt,$0,v[15:0]; op SIGNED_EXT; single beat.
  3. v[15:0]==0 -> LUI rt,v[31:16]; op SHIFTL16; single beat.
  4. otherwise -> beat0 LUI rt,v[31:16] (SHIFTL16, last=0); beat1 ORI rt,rt,v[15:0] (ZERO_EXT, last=1).
- Instruction format: {opcode[5:0], rs[4:0], rt[4:0], imm[15:0]}.
  - ORI=6'h0D, ADDIU=6'h09, LUI=6'h0F.
  - LUI rs=0.
  - Second-beat ORI rs=rt.
- FSM:
  - IDLE: on accept, load the output registers, then go to ONE (single-beat case) or FIRST (two-beat case).
  - ONE: on out_ready, go to IDLE and set out_valid=0.
  - FIRST: on out_ready, load the beat1 registers and go to SECOND. out_valid stays 1, so beat1 is valid the very next cycle.
  - SECOND: on out_ready, go to IDLE and set out_valid=0.
- Throughput: at most one constant per 2 cycles (single-beat case), or per 3 cycles (two-beat case).
- Low half of the constant and rt are latched at acceptance. in_value/in_rt changes after acceptance have no effect.
- rt=0 is encoded as-is; no special-casing.
- v=0 encodes as ORI $rt,$0,0 (rule 1).
- Reset asserted mid-sequence abandons the sequence. Outputs return to reset values on the next edge, with no partial beat afterwards.
- Invariant: feeding out_imm and out_op into the immediate extender, then applying ORI/ADDIU/LUI semantics, reproduces v exactly.

Decomposition:
- Add to AlicePU_const.vh: `OPC_ORI, `OPC_ADDIU, `OPC_LUI. Reuse the existing `IEXT_OP_* and `IEXT_OP_LEN.
- FSM state encodings stay local as localparams.
- One natural combinational sub-module: imm_mat_classify. It takes v and ALLOW_SIGNED and returns form select {ORI, ADDIU, LUI, PAIR}.
- The FSM/handshake logic stays in imm_materializer.

Test Plan:
- v=32'h0000_1234, rt=8, out_ready=1 -> one beat, cycle after accept: instr=32'h3408_1234, op=ZERO_EXT, last=1; in_ready back to 1 next cycle.
- v=32'hFFFF_FFFE, rt=9, ALLOW_SIGNED=1 -> instr=32'h2409_FFFE, op=SIGNED_EXT, last=1. With ALLOW_SIGNED=0 -> two beats: 32'h3C09_FFFF then 32'h3529_FFFE.
- v=32'h8000_0000, rt=3 -> single LUI 32'h3C03_8000, op=SHIFTL16, last=1.
- v=32'hDEAD_BEEF, rt=4, out_ready held low 3 cycles -> beat0 32'h3C04_DEAD is stable while stalled. After release, beat1 32'h3484_BEEF with last=1. in_ready=0 throughout the sequence.
- Two-beat sequence with rst asserted during SECOND -> next edge: out_valid=0, in_ready=1, state IDLE; no further beat.
- Random 10k constants passed through a reference model of the extender plus ALU semantics -> the reconstructed register value equals v, and the beat count is minimal per the rules.
